// File: rtl/btn_event_ctrl_pkg.sv
// Shared types for the switch event front-end.
// Event codes and channel-index width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_LONG    = 2'd3
    } evt_code_t;

    localparam int CH_W_MIN = 1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : CH_W_MIN;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Event port: one held event, valid/ready handshake.
// master = event producer, slave = consumer.
interface btn_event_ctrl_if
    import btn_pkg::*;
#(
    parameter int CH_W = 2
);

    logic            evt_valid_o;
    logic [CH_W-1:0] evt_ch_o;
    evt_code_t       evt_code_o;
    logic            evt_ready_i;

    modport master (
        output evt_valid_o,
        output evt_ch_o,
        output evt_code_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_ch_o,
        input  evt_code_o,
        output evt_ready_i
    );

endinterface

// File: rtl/btn_event_ctrl_db_channel.sv
// One switch channel: 2-FF sync, tick-based debounce,
// long-press hold counter and combinational event post.
module btn_db_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 500
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick,
    input  logic      sw,
    output logic      db,
    output logic      post,
    output evt_code_t code
);

    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    logic [1:0]    sync;
    logic [SW-1:0] stable;
    logic [HW-1:0] hold;
    logic          differ;
    logic          flip;
    logic          long_hit;

    always_comb begin
        differ   = sync[1] ^ db;
        flip     = tick & differ
                 & (stable == SW'(STABLE_TICKS - 1));
        // A release on the same tick outranks the long event.
        long_hit = tick & db & ~flip
                 & (hold == HW'(LONG_TICKS - 1));
        post     = flip | long_hit;
        code     = EVT_NONE;
        if (flip)
            code = db ? EVT_RELEASE : EVT_PRESS;
        else if (long_hit)
            code = EVT_LONG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= '0;
            hold   <= '0;
            db     <= 1'b0;
        end else begin
            sync <= {sync[0], sw};
            if (tick) begin
                if (!differ) begin
                    stable <= '0;
                end else if (flip) begin
                    stable <= '0;
                    db     <= ~db;
                end else begin
                    stable <= stable + 1'b1;
                end
            end
            if (!db)
                hold <= '0;
            else if (tick && hold != HW'(LONG_TICKS))
                hold <= hold + 1'b1;
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-channel debounce front-end with shared prescaler,
// per-channel pending store and round-robin event slot.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 500
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic [N_CH-1:0]    sw_i,
    output logic [N_CH-1:0]    db_o,
    btn_event_ctrl_if.master   evt,
    output logic [N_CH-1:0]    ovf_o,
    input  logic               ovf_clr_i
);

    localparam int CH_W = ch_w(N_CH);
    localparam int PW   = $clog2(TICK_DIV);

    logic [PW-1:0]   pre;
    logic            tick;
    logic [N_CH-1:0] post;
    evt_code_t       post_code [N_CH];
    logic [N_CH-1:0] pend;
    evt_code_t       pend_code [N_CH];
    logic [CH_W-1:0] rr;
    logic [CH_W-1:0] win;
    logic [CH_W-1:0] nxt;
    logic            found;
    logic            load;
    logic            take;
    logic [N_CH-1:0] take_vec;
    int              idx;

    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n)
            pre <= '0;
        else
            pre <= tick ? '0 : pre + 1'b1;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        btn_db_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk   (sysclk),
            .rst_n (reset_n),
            .tick  (tick),
            .sw    (sw_i[k]),
            .db    (db_o[k]),
            .post  (post[k]),
            .code  (post_code[k])
        );
    end

    // First pending channel at or after rr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr) + i;
            if (idx >= N_CH)
                idx = idx - N_CH;
            if (!found && pend[CH_W'(idx)]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        nxt      = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
        load     = ~evt.evt_valid_o | evt.evt_ready_i;
        take     = load & found;
        take_vec = '0;
        if (take)
            take_vec[win] = 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            pend            <= '0;
            ovf_o           <= '0;
            rr              <= '0;
            evt.evt_valid_o <= 1'b0;
            evt.evt_ch_o    <= '0;
            evt.evt_code_o  <= EVT_NONE;
            for (int k = 0; k < N_CH; k++)
                pend_code[k] <= EVT_NONE;
        end else begin
            if (ovf_clr_i)
                ovf_o <= '0;
            // A post racing the load of its own channel refills pend.
            for (int k = 0; k < N_CH; k++) begin
                if (post[k]) begin
                    pend[k]      <= 1'b1;
                    pend_code[k] <= post_code[k];
                    if (pend[k] && !take_vec[k])
                        ovf_o[k] <= 1'b1;
                end else if (take_vec[k]) begin
                    pend[k] <= 1'b0;
                end
            end
            if (load) begin
                evt.evt_valid_o <= found;
                if (found) begin
                    evt.evt_ch_o   <= win;
                    evt.evt_code_o <= pend_code[win];
                    rr             <= nxt;
                end
            end
        end
    end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Multi-channel switch front-end controller that debounces up to N_CH raw switch/button inputs using one shared tick prescaler. It converts debounced transitions into press, release and long-press events, and arbitrates those events round-robin onto a single valid/ready event port. It sits between board-level switch pins and the user logic or CSR block that consumes button events. It replaces per-switch free-running debounce instances.

## Interface
- N_CH, 4: number of switch channels (1..16).
- TICK_DIV, 100000: sysclk cycles per debounce tick (1 ms at 100 MHz); ≥2.
- STABLE_TICKS, 10: consecutive ticks of differing input needed to flip a debounced level; ≥1.
- LONG_TICKS, 500: ticks a level must stay 1 before a LONG event; > STABLE_TICKS.
- sysclk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sw_i  in  N_CH  raw asynchronous switch levels.
- db_o  out  N_CH  debounced levels.
- evt_valid_o  out  1  event slot holds a valid event.
- evt_ch_o  out  $clog2(N_CH) (min 1)  channel of the held event.
- evt_code_o  out  2  event code: 01 PRESS, 10 RELEASE, 11 LONG.
- evt_ready_i  in  1  consumer accepts the event.
- ovf_o  out  N_CH  sticky per-channel overflow (event lost).
- ovf_clr_i  in  1  single-cycle pulse that clears all ovf_o bits.

## Operation
- Reset (asynchronous assert, synchronous-release behaviour) drives the following to 0:
  - every output;
  - the synchronizers, prescaler, stable and hold counters;
  - the pending flags and the round-robin pointer.
- Prescaler counts 0..TICK_DIV-1. `tick` is a 1-cycle pulse on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- Each channel has a 2-FF synchronizer. On `tick`:
  - If sync ≠ db: stable count increments.
  - If sync = db: stable count clears.
  - When the increment would reach STABLE_TICKS: db toggles, the stable count clears, and a PRESS (new db=1) or RELEASE (new db=0) is posted.
  - Hold counter: on `tick` while db=1, it increments and saturates at LONG_TICKS. On reaching LONG_TICKS it posts LONG, exactly once per press. It clears whenever db=0.
- Pending store, per channel: a pend bit plus a 2-bit code.
  - A post while pend=1 overwrites the code and sets ovf_o[k].
  - A post on the same cycle the channel is loaded into the slot becomes the new pending entry; ovf is not set.
- Event slot (1 entry) loads when evt_valid_o=0, or when evt_valid_o & evt_ready_i.
  - Load winner: the first pending channel at or after the rr pointer, wrapping modulo N_CH.
  - On load: that channel's pend clears, and rr becomes winner+1 (mod N_CH).
  - No pending channel: evt_valid_o drops after a handshake.
- ch/code stay stable while valid & !ready. evt_valid_o never drops without a handshake.
- ovf_clr_i and a simultaneous new overflow: the set wins.

## Timing
- Raw edge to db_o:
  - 2 cycles of synchronization, then STABLE_TICKS ticks.
  - Total latency from the first stable tick: (STABLE_TICKS-1)·TICK_DIV + 1..TICK_DIV cycles + 2.
- db_o updates on the `tick` cycle. The pend bit sets on the same edge.
- evt_valid_o rises 1 cycle after the post when the slot is free.
- Back-to-back events: one per cycle when evt_ready_i is held 1.
- Bouncing input (any tick with sync = db inside the window) restarts the count. No event is produced.

## Structure
- Package btn_pkg holds:
  - typedef enum logic [1:0] evt_code_t: EVT_NONE=0, EVT_PRESS=1, EVT_RELEASE=2, EVT_LONG=3;
  - the localparam for the channel-index width helper.
- Sub-module btn_db_channel (one per channel, via generate) contains the synchronizer, stable counter, hold counter and post output.
- The prescaler, pending store, arbiter and output slot stay in the top level.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, N_CH=4.

- **Reset mid-debounce:** sw_i[0]=1 for 2 ticks, then reset_n=0 → db_o=0, evt_valid_o=0, ovf_o=0 immediately. After release, 3 more ticks are required before db_o[0]=1.
- **Bounce rejection:** sw_i[1] toggles every 3 cycles for 40 cycles, then settles at 1 → no event during bouncing. One PRESS on ch 1 arrives 3 ticks after settling; db_o[1]=1.
- **Long press:** sw_i[2] held 1 → PRESS, then LONG exactly 8 ticks after db rose, with no second LONG. Releasing gives RELEASE.
- **Round-robin:** PRESS pending on ch 0, 1 and 3 in the same cycle, with evt_ready_i=1 → events in ch order 0, 1, 3 on consecutive cycles, then evt_valid_o=0.
- **Backpressure and overflow:** evt_ready_i=0, ch 0 PRESS then RELEASE while its first event occupies the slot and a second is pending → slot holds PRESS with stable outputs, and ovf_o[0]=1. An ovf_clr_i pulse clears it.
- **Handshake/post collision:** a new post on ch 2 lands on the same cycle ch 2 is loaded → the new event is pending and delivered next, with ovf_o[2]=0.
